// File: rtl/accumulator_pkg.sv
// ----------------------------------------------------------------------------
// accumulator_pkg
//   Shared definitions for the accumulator memory/processor pair and benches:
//   memory op codes, one-hot processor state encoding and default widths.
// ----------------------------------------------------------------------------
package accumulator_pkg;

  localparam int unsigned ACC_DATA_W       = 32;
  localparam int unsigned ACC_NUM_OPERANDS = 1024;
  localparam int unsigned ACC_CNT_W        = 10;
  localparam int unsigned OP_W             = 2;
  localparam int unsigned STATE_W          = 6;

  // Memory request codes (same encoding on both sides of the link).
  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 2'b00,
    OP_FETCH = 2'b01,
    OP_SEND  = 2'b10
  } op_t;

  // One-hot processor states; exported on the debug state port.
  typedef enum logic [STATE_W-1:0] {
    ST_INI     = 6'b000001,
    ST_FETCH_A = 6'b000010,
    ST_FETCH_B = 6'b000100,
    ST_ADD     = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_DONE    = 6'b100000
  } state_t;

  // Memory request implied by a state; gap marks the one-cycle NOP before a FETCH.
  function automatic op_t state_op(input state_t s, input logic gap);
    op_t o;
    o = OP_NOP;
    case (s)
      ST_FETCH_A,
      ST_FETCH_B: o = gap ? OP_NOP : OP_FETCH;
      ST_SEND:    o = OP_SEND;
      default:    o = OP_NOP;
    endcase
    return o;
  endfunction

endpackage : accumulator_pkg

// File: rtl/accumulator_adder.sv
// ----------------------------------------------------------------------------
// accumulator_adder
//   Combinational unsigned DATA_W adder with carry out.
//   Build option ACC_SATURATE_EN: when defined, a carry clamps the sum to
//   all-ones; when undefined the sum wraps modulo 2^DATA_W. The carry output
//   reports the overflow in both builds.
// Ports
//   i_a, i_b  in  DATA_W  operands
//   o_sum     out DATA_W  wrapped or saturated sum
//   o_carry   out 1       carry out of bit DATA_W-1
// ----------------------------------------------------------------------------
module accumulator_adder
  import accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = ACC_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  localparam int unsigned FULL_W = DATA_W + 1;

  logic [FULL_W-1:0] w_full;

  // One extra bit keeps the carry.
  assign w_full  = FULL_W'(i_a) + FULL_W'(i_b);
  assign o_carry = w_full[DATA_W];

`ifdef ACC_SATURATE_EN
  assign o_sum = w_full[DATA_W] ? {DATA_W{1'b1}} : w_full[DATA_W-1:0];
`else
  assign o_sum = w_full[DATA_W-1:0];
`endif

endmodule : accumulator_adder

// File: rtl/accumulator_processor.sv
// ----------------------------------------------------------------------------
// accumulator_processor
//   Reduction stage behind accumulator_memory. After the memory reports full it
//   repeatedly fetches two operands, adds them and sends the sum back, until
//   NUM_OPERANDS values have been folded into one total (NUM_OPERANDS-1 adds).
//   Build option ACC_SATURATE_EN (see accumulator_adder) selects saturating
//   instead of wrapping addition.
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous active-low reset
//   mem_full   in   1        memory load complete, start processing
//   op         out  2        memory request NOP/FETCH/SEND
//   signal     in   1        memory ack pulse (read valid / write taken)
//   read       in   DATA_W   fetched operand
//   write      out  DATA_W   sum presented to memory during SEND
//   result     out  DATA_W   last sum; final total once done
//   add_count  out  CNT_W    acknowledged additions
//   overflow   out  1        sticky carry-out flag
//   done       out  1        reduction complete
//   state      out  6        one-hot state (debug)
// ----------------------------------------------------------------------------
module accumulator_processor
  import accumulator_pkg::*;
#(
  parameter int unsigned DATA_W       = ACC_DATA_W,
  parameter int unsigned NUM_OPERANDS = ACC_NUM_OPERANDS,
  parameter int unsigned CNT_W        = ACC_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_full,
  output logic [OP_W-1:0]    op,
  input  logic               signal,
  input  logic [DATA_W-1:0]  read,
  output logic [DATA_W-1:0]  write,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   add_count,
  output logic               overflow,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  // Count value (before increment) of the SEND that completes the reduction.
  localparam logic [CNT_W-1:0] LAST_ADD = CNT_W'(NUM_OPERANDS - 2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_gap;
  logic              w_gap_nxt;
  op_t               r_op;
  op_t               w_op_nxt;
  logic              r_done;
  logic              w_done_nxt;

  logic              w_ack_a;
  logic              w_ack_b;
  logic              w_ack_send;
  logic              w_last_add;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_write;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_add_count;
  logic              r_overflow;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;

  // Adder datapath
  accumulator_adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_last_add = (r_add_count == LAST_ADD);

  // State register; r_gap marks the NOP cycle preceding a FETCH request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INI;
      r_gap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Next-state logic; acks only count while the matching request is on op.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_ack_a     = 1'b0;
    w_ack_b     = 1'b0;
    w_ack_send  = 1'b0;
    case (r_state)
      ST_INI: begin
        if (mem_full) begin
          w_state_nxt = ST_FETCH_A;
          w_gap_nxt   = 1'b0;
        end
      end
      ST_FETCH_A: begin
        if (r_gap) begin
          w_gap_nxt = 1'b0;
        end else if (signal) begin
          w_ack_a     = 1'b1;
          w_state_nxt = ST_FETCH_B;
          w_gap_nxt   = 1'b1;
        end
      end
      ST_FETCH_B: begin
        if (r_gap) begin
          w_gap_nxt = 1'b0;
        end else if (signal) begin
          w_ack_b     = 1'b1;
          w_state_nxt = ST_ADD;
          w_gap_nxt   = 1'b0;
        end
      end
      ST_ADD: begin
        w_state_nxt = ST_SEND;
        w_gap_nxt   = 1'b0;
      end
      ST_SEND: begin
        if (signal) begin
          w_ack_send = 1'b1;
          if (w_last_add) begin
            w_state_nxt = ST_DONE;
            w_gap_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_FETCH_A;
            w_gap_nxt   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
        w_gap_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = ST_INI;
        w_gap_nxt   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so op/done register alongside the state.
  always_comb begin
    w_op_nxt   = OP_NOP;
    w_done_nxt = 1'b0;
    w_op_nxt   = state_op(w_state_nxt, w_gap_nxt);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Registered FSM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op   <= OP_NOP;
      r_done <= 1'b0;
    end else begin
      r_op   <= w_op_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand capture, sum/result registers, sticky overflow and add counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_write     <= '0;
      r_result    <= '0;
      r_add_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_ack_a) begin
        r_a <= read;
      end
      if (w_ack_b) begin
        r_b <= read;
      end
      if (r_state == ST_ADD) begin
        r_write    <= w_sum;
        r_result   <= w_sum;
        r_overflow <= r_overflow | w_carry;
      end
      if (w_ack_send) begin
        r_add_count <= r_add_count + CNT_W'(1);
      end
    end
  end

  assign op        = r_op;
  assign done      = r_done;
  assign state     = r_state;
  assign write     = r_write;
  assign result    = r_result;
  assign add_count = r_add_count;
  assign overflow  = r_overflow;

endmodule : accumulator_processor
